// File: rtl/lsu_ac_arb.sv
// Load/store address-check arbiter: round-robin pick of one load or store
// request, alignment/access check, one registered output slot, halt on fault.
//
// Ports:
//   clk, rstn                       clock, async active-low reset
//   ld_* / st_*                     load / store request (valid, ready, tag,
//                                   size, address)
//   flush_i                         drop held entry, leave HALT
//   out_valid_o / out_ready_i       output handshake
//   out_opcode_o                    0 load, 1 store
//   out_rd_addr_o, out_size_o,
//   out_addr_o                      registered request fields
//   out_ecause_o, out_exc_valid_o   checked exception of the held entry
//   halted_o                        high while halted on a faulting entry
module lsu_ac_arb #(
   parameter int PHY_REG_ADDR_WIDTH   = 6,
   parameter int VIRTUAL_ADDR_LEN     = 39,
   parameter int EXCEPTION_CODE_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            ld_valid_i,
   output logic                            ld_ready_o,
   input  logic [PHY_REG_ADDR_WIDTH-1:0]   ld_rd_addr_i,
   input  logic [1:0]                      ld_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0]     ld_addr_i,
   input  logic                            st_valid_i,
   output logic                            st_ready_o,
   input  logic [PHY_REG_ADDR_WIDTH-1:0]   st_rd_addr_i,
   input  logic [1:0]                      st_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0]     st_addr_i,
   input  logic                            flush_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic                            out_opcode_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0]   out_rd_addr_o,
   output logic [1:0]                      out_size_o,
   output logic [VIRTUAL_ADDR_LEN-1:0]     out_addr_o,
   output logic [EXCEPTION_CODE_WIDTH-1:0] out_ecause_o,
   output logic                            out_exc_valid_o,
   output logic                            halted_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state;
   logic   last_st;

   logic                            pick_st;
   logic                            can_acc;
   logic                            accept;
   logic                            hs;
   logic [PHY_REG_ADDR_WIDTH-1:0]   sel_rd;
   logic [1:0]                      sel_size;
   logic [VIRTUAL_ADDR_LEN-1:0]     sel_addr;
   logic                            fault;
   logic                            mis;
   logic [EXCEPTION_CODE_WIDTH-1:0] ecause;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [2:0] low
   );
      logic m;
      case (size)
         2'b00:   m = 1'b0;
         2'b01:   m = low[0];
         2'b10:   m = |low[1:0];
         default: m = |low;
      endcase
      return m;
   endfunction

   // On contention the store wins only if the load was granted last.
   assign pick_st = st_valid_i & (~ld_valid_i | ~last_st);

   // A faulting entry in the slot must drain into HALT, so no accept then.
   // rstn gating keeps readies low while reset is held.
   assign can_acc = rstn & ~flush_i &
                    ((state == EMPTY) |
                     ((state == FULL) & out_ready_i & ~out_exc_valid_o));

   assign ld_ready_o = can_acc & ld_valid_i & ~pick_st;
   assign st_ready_o = can_acc & pick_st;
   assign accept     = ld_ready_o | st_ready_o;
   assign hs         = out_valid_o & out_ready_i;

   assign sel_rd   = pick_st ? st_rd_addr_i : ld_rd_addr_i;
   assign sel_size = pick_st ? st_size_i    : ld_size_i;
   assign sel_addr = pick_st ? st_addr_i    : ld_addr_i;

   always_comb begin
      fault  = (sel_rd == '0);
      mis    = misaligned(sel_size, sel_addr[2:0]);
      ecause = '0;
      if (fault) begin
         ecause = pick_st ? EXCEPTION_CODE_WIDTH'(7) :
                            EXCEPTION_CODE_WIDTH'(5);
      end else if (mis) begin
         ecause = pick_st ? EXCEPTION_CODE_WIDTH'(6) :
                            EXCEPTION_CODE_WIDTH'(4);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= EMPTY;
         last_st         <= 1'b1;
         out_valid_o     <= 1'b0;
         out_opcode_o    <= 1'b0;
         out_rd_addr_o   <= '0;
         out_size_o      <= '0;
         out_addr_o      <= '0;
         out_ecause_o    <= '0;
         out_exc_valid_o <= 1'b0;
         halted_o        <= 1'b0;
      end else if (flush_i) begin
         state           <= EMPTY;
         out_valid_o     <= 1'b0;
         out_exc_valid_o <= 1'b0;
         halted_o        <= 1'b0;
      end else if (accept) begin
         state           <= FULL;
         last_st         <= pick_st;
         out_valid_o     <= 1'b1;
         out_opcode_o    <= pick_st;
         out_rd_addr_o   <= sel_rd;
         out_size_o      <= sel_size;
         out_addr_o      <= sel_addr;
         out_ecause_o    <= ecause;
         out_exc_valid_o <= fault | mis;
      end else begin
         unique case (state)
            FULL: begin
               if (hs) begin
                  out_valid_o     <= 1'b0;
                  out_exc_valid_o <= 1'b0;
                  if (out_exc_valid_o) begin
                     state    <= HALT;
                     halted_o <= 1'b1;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            HALT:    state <= HALT;
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ac_arb.sv
// Testbench for lsu_ac_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_lsu_ac_arb;
   localparam int PW = 6;
   localparam int VW = 39;
   localparam int EW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ld_valid_i = 1'b0;
   logic          ld_ready_o;
   logic [PW-1:0] ld_rd_addr_i = '0;
   logic [1:0]    ld_size_i = '0;
   logic [VW-1:0] ld_addr_i = '0;
   logic          st_valid_i = 1'b0;
   logic          st_ready_o;
   logic [PW-1:0] st_rd_addr_i = '0;
   logic [1:0]    st_size_i = '0;
   logic [VW-1:0] st_addr_i = '0;
   logic          flush_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic          out_opcode_o;
   logic [PW-1:0] out_rd_addr_o;
   logic [1:0]    out_size_o;
   logic [VW-1:0] out_addr_o;
   logic [EW-1:0] out_ecause_o;
   logic          out_exc_valid_o;
   logic          halted_o;

   lsu_ac_arb #(
      .PHY_REG_ADDR_WIDTH  (PW),
      .VIRTUAL_ADDR_LEN    (VW),
      .EXCEPTION_CODE_WIDTH(EW)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .ld_valid_i     (ld_valid_i),
      .ld_ready_o     (ld_ready_o),
      .ld_rd_addr_i   (ld_rd_addr_i),
      .ld_size_i      (ld_size_i),
      .ld_addr_i      (ld_addr_i),
      .st_valid_i     (st_valid_i),
      .st_ready_o     (st_ready_o),
      .st_rd_addr_i   (st_rd_addr_i),
      .st_size_i      (st_size_i),
      .st_addr_i      (st_addr_i),
      .flush_i        (flush_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_opcode_o   (out_opcode_o),
      .out_rd_addr_o  (out_rd_addr_o),
      .out_size_o     (out_size_o),
      .out_addr_o     (out_addr_o),
      .out_ecause_o   (out_ecause_o),
      .out_exc_valid_o(out_exc_valid_o),
      .halted_o       (halted_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: one slot holding a transaction, a halt flag, last winner.
   bit            m_valid;
   bit            m_op;
   logic [PW-1:0] m_rd;
   logic [1:0]    m_size;
   logic [VW-1:0] m_addr;
   logic [EW-1:0] m_cause;
   bit            m_exc;
   bit            m_halt;
   bit            m_last_st;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] cause_of(input bit st,
      input logic [PW-1:0] rd, input logic [1:0] sz,
      input logic [VW-1:0] a);
      longint unsigned bytes = 64'd1 << sz;
      bit mis = ((64'(a) % bytes) != 0);
      if (rd == 0) return st ? EW'(7) : EW'(5);
      if (mis) return st ? EW'(6) : EW'(4);
      return EW'(0);
   endfunction

   task automatic model_reset();
      m_valid   = 0;
      m_halt    = 0;
      m_exc     = 0;
      m_last_st = 1;
   endtask

   // Called just after a negedge with inputs driven; checks, then steps.
   task automatic cycle();
      bit open, pst, el, es, hs;
      #1;
      open = !m_halt && !flush_i &&
             (!m_valid || (out_ready_i && !m_exc));
      pst  = st_valid_i && (!ld_valid_i || !m_last_st);
      es   = open && pst;
      el   = open && ld_valid_i && !pst;
      chk("ld_ready", ld_ready_o, el);
      chk("st_ready", st_ready_o, es);
      chk("out_valid", out_valid_o, m_valid);
      chk("halted", halted_o, m_halt);
      if (m_valid) begin
         chk("opcode", out_opcode_o, m_op);
         chk("rd", out_rd_addr_o, m_rd);
         chk("size", out_size_o, m_size);
         chk("addr", out_addr_o, m_addr);
         chk("ecause", out_ecause_o, m_cause);
         chk("exc_valid", out_exc_valid_o, m_exc);
      end
      @(posedge clk);
      hs = m_valid && out_ready_i;
      if (flush_i) begin
         m_valid = 0;
         m_halt  = 0;
      end else if (!m_halt) begin
         if (hs && m_exc) begin
            m_valid = 0;
            m_halt  = 1;
         end else if (el || es) begin
            m_valid   = 1;
            m_op      = es;
            m_rd      = es ? st_rd_addr_i : ld_rd_addr_i;
            m_size    = es ? st_size_i : ld_size_i;
            m_addr    = es ? st_addr_i : ld_addr_i;
            m_cause   = cause_of(es, m_rd, m_size, m_addr);
            m_exc     = (m_cause != 0);
            m_last_st = es;
         end else if (hs) begin
            m_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      #1;
      chk({tag, " out_valid"}, out_valid_o, 0);
      chk({tag, " ld_ready"}, ld_ready_o, 0);
      chk({tag, " st_ready"}, st_ready_o, 0);
      chk({tag, " halted"}, halted_o, 0);
      chk({tag, " exc"}, out_exc_valid_o, 0);
   endtask

   task automatic set_ld(input bit v, input int rd, input int sz,
                         input longint a);
      ld_valid_i   = v;
      ld_rd_addr_i = PW'(rd);
      ld_size_i    = 2'(sz);
      ld_addr_i    = VW'(a);
   endtask

   task automatic set_st(input bit v, input int rd, input int sz,
                         input longint a);
      st_valid_i   = v;
      st_rd_addr_i = PW'(rd);
      st_size_i    = 2'(sz);
      st_addr_i    = VW'(a);
   endtask

   initial begin
      model_reset();
      rstn = 1'b0;
      set_ld(1, 3, 2, 'h100);
      set_st(1, 4, 2, 'h200);
      out_ready_i = 1;
      @(negedge clk);
      reset_checks("rst");
      @(negedge clk);
      rstn = 1'b1;

      // Alternating grants under contention, load first.
      #1 chk("rr0 ld_ready", ld_ready_o, 1);
      chk("rr0 st_ready", st_ready_o, 0);
      cycle();
      #1 chk("rr1 valid", out_valid_o, 1);
      chk("rr1 op", out_opcode_o, 0);
      chk("rr1 st_ready", st_ready_o, 1);
      cycle();
      #1 chk("rr2 op", out_opcode_o, 1);
      chk("rr2 ld_ready", ld_ready_o, 1);
      cycle();
      #1 chk("rr3 op", out_opcode_o, 0);
      set_ld(0, 3, 2, 'h100);
      set_st(0, 4, 2, 'h200);
      cycle();

      // Misaligned word load halts until flush.
      set_ld(1, 5, 2, 'h1002);
      out_ready_i = 0;
      cycle();
      #1 chk("mis ecause", out_ecause_o, 4);
      chk("mis exc", out_exc_valid_o, 1);
      ld_valid_i  = 0;
      out_ready_i = 1;
      cycle();
      ld_valid_i = 1;
      #1 chk("halt halted", halted_o, 1);
      chk("halt ld_ready", ld_ready_o, 0);
      chk("halt valid", out_valid_o, 0);
      cycle();
      flush_i = 1;
      cycle();
      flush_i = 0;
      ld_valid_i = 0;
      #1 chk("unhalt halted", halted_o, 0);

      // Store access fault beats misalign.
      set_st(1, 0, 1, 'h3);
      cycle();
      st_valid_i = 0;
      #1 chk("acc ecause", out_ecause_o, 7);
      chk("acc exc", out_exc_valid_o, 1);
      flush_i = 1;
      cycle();
      flush_i = 0;

      // Stall for three cycles, then back-to-back.
      set_ld(1, 9, 3, 'h40);
      set_st(1, 10, 0, 'h41);
      out_ready_i = 0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall ready", ld_ready_o | st_ready_o, 0);
         cycle();
      end
      out_ready_i = 1;
      #1 chk("resume ready", ld_ready_o | st_ready_o, 1);
      cycle();
      cycle();

      // Flush during handshake with a new request.
      flush_i = 1;
      #1 chk("flush ready", ld_ready_o | st_ready_o, 0);
      cycle();
      flush_i = 0;
      #1 chk("flush valid", out_valid_o, 0);
      cycle();

      // Reset while FULL clears output asynchronously.
      #2 rstn = 1'b0;
      model_reset();
      reset_checks("async");
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("post rst ld_ready", ld_ready_o, 1);

      for (int i = 0; i < 3000; i++) begin
         ld_valid_i   = ($urandom_range(0, 9) < 7);
         st_valid_i   = ($urandom_range(0, 9) < 7);
         ld_rd_addr_i = ($urandom_range(0, 7) == 0) ? '0 :
                        PW'($urandom_range(1, 63));
         st_rd_addr_i = ($urandom_range(0, 7) == 0) ? '0 :
                        PW'($urandom_range(1, 63));
         ld_size_i    = 2'($urandom_range(0, 3));
         st_size_i    = 2'($urandom_range(0, 3));
         ld_addr_i    = VW'({$urandom(), $urandom()});
         st_addr_i    = VW'({$urandom(), $urandom()});
         if ($urandom_range(0, 2) != 0) ld_addr_i[2:0] = 3'b0;
         if ($urandom_range(0, 2) != 0) st_addr_i[2:0] = 3'b0;
         flush_i      = ($urandom_range(0, 11) == 0);
         out_ready_i  = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
